// File: rtl/fetch_execute_stage.sv
// Fetch/execute front end of a single-cycle MIPS datapath: PC, word-addressed imem, next-PC select and ALU.
module fetch_execute_stage #(
  parameter int IMEM_AW   = 6,
  parameter     IMEM_FILE = "imem.hex"
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_write,
  input  logic               jump,
  input  logic               branch,
  input  logic               alu_src,
  input  logic [1:0]         alu_op,
  input  logic [3:0]         funct_c,
  input  logic [31:0]        sign_ext,
  input  logic [31:0]        mem1_read,
  input  logic [31:0]        mem2_read,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  output logic [31:0]        pc,
  output logic [31:0]        inst,
  output logic [31:0]        if_out,
  output logic [31:0]        alu_result,
  output logic               zero,
  output logic [31:0]        mx2
);
  localparam int DEPTH = 1 << IMEM_AW;

  logic [31:0] pc_q, pc_d;
  logic [31:0] imem_q [DEPTH];
  logic [31:0] br_tgt, jmp_tgt, alu_b;

  // Memory is deliberately outside the reset domain so a reset never wipes a loaded program.
  always_ff @(posedge clk) begin
    if (imem_we) imem_q[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        pc_q <= 32'h0;
    else if (pc_write) pc_q <= pc_d;
  end

  assign pc      = pc_q;
  assign inst    = imem_q[pc_q[IMEM_AW+1:2]];
  assign if_out  = pc_q + 32'd4;
  assign br_tgt  = if_out + (sign_ext << 2);
  assign mx2     = (branch && zero) ? br_tgt : if_out;
  assign jmp_tgt = {if_out[31:28], inst[25:0], 2'b00};
  assign pc_d    = jump ? jmp_tgt : mx2;

  assign alu_b = alu_src ? sign_ext : mem2_read;

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      2'b00: alu_result = mem1_read + alu_b;
      2'b01: alu_result = mem1_read - alu_b;
      2'b11: alu_result = mem1_read | alu_b;
      default: begin
        case (funct_c)
          4'b0000: alu_result = mem1_read & alu_b;
          4'b0001: alu_result = mem1_read | alu_b;
          4'b0010: alu_result = mem1_read + alu_b;
          4'b0110: alu_result = mem1_read - alu_b;
          4'b0111: alu_result = ($signed(mem1_read) < $signed(alu_b)) ? 32'd1 : 32'd0;
          4'b1100: alu_result = ~(mem1_read | alu_b);
          default: alu_result = 32'h0;
        endcase
      end
    endcase
  end

  assign zero = (alu_result == 32'h0);
endmodule

// File: tb/tb_fetch_execute_stage.sv
// Scoreboard bench for fetch_execute_stage: expected values queued at drive time, popped at sample time.
module tb_fetch_execute_stage;
    logic        clk = 1'b0;
    logic        reset, pc_write, jump, branch, alu_src, imem_we;
    logic [1:0]  alu_op;
    logic [3:0]  funct_c;
    logic [31:0] sign_ext, mem1_read, mem2_read, imem_wdata;
    logic [5:0]  imem_waddr;
    logic [31:0] pc, inst, if_out, alu_result, mx2;
    logic        zero;

    typedef struct { string name; logic [31:0] val; } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_execute_stage #(.IMEM_AW(6)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .jump(jump), .branch(branch),
        .alu_src(alu_src), .alu_op(alu_op), .funct_c(funct_c), .sign_ext(sign_ext),
        .mem1_read(mem1_read), .mem2_read(mem2_read), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .pc(pc), .inst(inst),
        .if_out(if_out), .alu_result(alu_result), .zero(zero), .mx2(mx2)
    );

    task automatic push(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Pulse reset away from the clock edge, then advance n cycles sequentially (pc = 4*n).
    task automatic goto_pc(input int n);
        @(negedge clk);
        reset = 1'b0; #1;
        reset = 1'b1; pc_write = 1'b1; jump = 1'b0; branch = 1'b0; imem_we = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        #9;
        push("reset_pc", 32'h0);
        e = sb.pop_front(); n_chk++;
        if (pc !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, pc, e.val); end
        push("reset_zero", 32'h1);
        e = sb.pop_front(); n_chk++;
        if ({31'h0, zero} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, zero, e.val); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            push("seq_pc", 32'(4 * i));
            push("seq_if_out", 32'(4 * i + 4));
            e = sb.pop_front(); n_chk++;
            if (pc !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, pc, e.val); end
            e = sb.pop_front(); n_chk++;
            if (if_out !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, if_out, e.val); end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        goto_pc(2);
        pc_write = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            push("hold_pc", 32'h8);
            e = sb.pop_front(); n_chk++;
            if (pc !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, pc, e.val); end
        end
        #2;
        reset = 1'b0; #1;
        push("async_rst_pc", 32'h0);
        push("async_rst_if_out", 32'h4);
        e = sb.pop_front(); n_chk++;
        if (pc !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, pc, e.val); end
        e = sb.pop_front(); n_chk++;
        if (if_out !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, if_out, e.val); end
        reset = 1'b1;
    endtask

    task automatic test_branch();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            goto_pc(2);
            branch = 1'b1; alu_op = 2'b01; alu_src = 1'b0;
            mem1_read = 32'd5; mem2_read = (k == 0) ? 32'd5 : 32'd6; sign_ext = 32'd3;
            #1;
            push("br_zero", (k == 0) ? 32'h1 : 32'h0);
            push("br_mx2", (k == 0) ? 32'h18 : 32'h0C);
            e = sb.pop_front(); n_chk++;
            if ({31'h0, zero} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, zero, e.val); end
            e = sb.pop_front(); n_chk++;
            if (mx2 !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, mx2, e.val); end
            @(posedge clk); #1;
            push("br_next_pc", (k == 0) ? 32'h18 : 32'h0C);
            e = sb.pop_front(); n_chk++;
            if (pc !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, pc, e.val); end
        end
    endtask

    task automatic test_jump();
        exp_t e;
        @(negedge clk);
        imem_we = 1'b1; imem_waddr = 6'd2; imem_wdata = 32'h0800_0010;
        @(negedge clk);
        imem_we = 1'b0;
        goto_pc(2);
        push("jmp_inst", 32'h0800_0010);
        e = sb.pop_front(); n_chk++;
        if (inst !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, inst, e.val); end
        jump = 1'b1;
        @(posedge clk); #1;
        push("jmp_pc", 32'h40);
        e = sb.pop_front(); n_chk++;
        if (pc !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, pc, e.val); end
        // Branch condition is true here, but jump must still win.
        goto_pc(2);
        jump = 1'b1; branch = 1'b1; alu_op = 2'b01; alu_src = 1'b0;
        mem1_read = 32'd5; mem2_read = 32'd5; sign_ext = 32'd3;
        @(posedge clk); #1;
        push("jmp_over_br_pc", 32'h40);
        e = sb.pop_front(); n_chk++;
        if (pc !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, pc, e.val); end
        // Write the currently addressed word, then jump past the memory depth to check wrap.
        pc_write = 1'b0; jump = 1'b0; branch = 1'b0;
        imem_we = 1'b1; imem_waddr = 6'd16; imem_wdata = 32'h0800_0042;
        @(posedge clk); #1;
        imem_we = 1'b0;
        push("wr_cur_inst", 32'h0800_0042);
        e = sb.pop_front(); n_chk++;
        if (inst !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, inst, e.val); end
        jump = 1'b1; pc_write = 1'b1;
        @(posedge clk); #1;
        push("wrap_pc", 32'h108);
        push("wrap_inst", 32'h0800_0010);
        e = sb.pop_front(); n_chk++;
        if (pc !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, pc, e.val); end
        e = sb.pop_front(); n_chk++;
        if (inst !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, inst, e.val); end
        jump = 1'b0;
    endtask

    task automatic test_alu();
        exp_t e;
        logic [1:0]  ops  [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
        logic [3:0]  fns  [10] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'hC, 4'hF, 4'h7, 4'h0, 4'h0, 4'h0};
        logic [31:0] as   [10] = '{32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFF, 32'h3};
        logic [31:0] bs   [10] = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h3, 32'h3, 32'h1, 32'h3, 32'h1, 32'h7};
        logic [31:0] exps [10] = '{32'h3, 32'h7, 32'hA, 32'h4, 32'hFFFF_FFF8, 32'h0, 32'h1, 32'h7, 32'h0, 32'hFFFF_FFFC};
        pc_write = 1'b0; branch = 1'b0; jump = 1'b0; alu_src = 1'b0;
        for (int i = 0; i < 10; i++) begin
            alu_op = ops[i]; funct_c = fns[i]; mem1_read = as[i]; mem2_read = bs[i];
            push($sformatf("alu_%0d", i), exps[i]);
            push($sformatf("alu_zero_%0d", i), (exps[i] == 32'h0) ? 32'h1 : 32'h0);
            #1;
            e = sb.pop_front(); n_chk++;
            if (alu_result !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, alu_result, e.val); end
            e = sb.pop_front(); n_chk++;
            if ({31'h0, zero} !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, zero, e.val); end
        end
    endtask

    task automatic test_alu_src();
        exp_t e;
        alu_src = 1'b1; alu_op = 2'b00; sign_ext = 32'hFFFF_FFFC;
        mem1_read = 32'h10; mem2_read = 32'h1234;
        push("alu_src_imm", 32'hC);
        #1;
        e = sb.pop_front(); n_chk++;
        if (alu_result !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, alu_result, e.val); end
        alu_src = 1'b0;
        push("alu_src_reg", 32'h1244);
        #1;
        e = sb.pop_front(); n_chk++;
        if (alu_result !== e.val) begin n_fail++; $display("FAIL %s: got %h want %h", e.name, alu_result, e.val); end
    endtask

    initial begin
        reset = 1'b0; pc_write = 1'b1; jump = 1'b0; branch = 1'b0; alu_src = 1'b0;
        alu_op = 2'b01; funct_c = 4'h0; sign_ext = 32'h0; mem1_read = 32'h0; mem2_read = 32'h0;
        imem_we = 1'b0; imem_waddr = 6'h0; imem_wdata = 32'h0;
        test_reset();
        test_hold();
        test_branch();
        test_jump();
        test_alu();
        test_alu_src();
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
